fft_frame_sched: RTL and testbench



---
 rtl/fft_pkg.sv | 19 +
 rtl/fft_frame_sched_sat_cnt8.sv | 35 +++
 rtl/fft_frame_sched.sv | 158 +++++++++++++++
 tb/tb_fft_frame_sched.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT frame scheduler.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    OUTPUT  = 2'd3
  } state_t;

  localparam int FFT_N          = 16;
  localparam int FFT_STAGES     = 4;
  localparam int BFLY_PER_STAGE = 8;

  localparam int CNT_W   = 8;
  localparam int STAGE_W = 2;
  localparam int GRP_W   = 3;

endpackage

// File: rtl/fft_frame_sched_sat_cnt8.sv
// 8-bit event counter; SATURATE=1 holds at all-ones, SATURATE=0 wraps.
module sat_cnt8
  import fft_pkg::*;
#(
  parameter bit SATURATE = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_max;

  assign w_at_max = (r_cnt == {CNT_W{1'b1}});

  // Count increments, holding at the top when saturating.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      if (SATURATE && w_at_max) begin
        r_cnt <= r_cnt;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/fft_frame_sched.sv
// Sequences frame load, four radix-2 stages of butterfly groups and the
// result handshake, with one frame of lookahead and drop accounting.
module fft_frame_sched
  import fft_pkg::*;
#(
  parameter int BFLY_UNITS = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_x_valid,
  input  logic               i_out_ready,
  output logic               o_load_frame,
  output logic               o_bfly_en,
  output logic [STAGE_W-1:0] o_stage,
  output logic [GRP_W-1:0]   o_grp,
  output logic               o_fft_valid,
  output logic               o_busy,
  output logic               o_overrun,
  output logic [CNT_W-1:0]   o_frame_cnt,
  output logic [CNT_W-1:0]   o_drop_cnt
);

  localparam int                 GRP_CYC    = BFLY_PER_STAGE / BFLY_UNITS;
  localparam logic [GRP_W-1:0]   LAST_GRP   = GRP_W'(GRP_CYC - 1);
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(FFT_STAGES - 1);

  state_t             r_state;
  logic [STAGE_W-1:0] r_stage;
  logic [GRP_W-1:0]   r_grp;
  logic               r_load_frame;
  logic               r_bfly_en;
  logic               r_fft_valid;
  logic               r_busy;
  logic               r_pend;
  logic               r_overrun;

  logic w_accept;
  logic w_enter_load;
  logic w_drop;

  // A frame is started from IDLE on a new or queued frame, or straight out
  // of OUTPUT on acceptance so back-to-back frames see no IDLE bubble.
  assign w_accept     = (r_state == OUTPUT) && i_out_ready;
  assign w_enter_load = ((r_state == IDLE) && (i_x_valid || r_pend)) ||
                        (w_accept && (i_x_valid || r_pend));
  assign w_drop       = i_x_valid && r_pend && !w_enter_load;

  // Main sequencer: state, stage/group counters and registered strobes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_stage      <= '0;
      r_grp        <= '0;
      r_load_frame <= 1'b0;
      r_bfly_en    <= 1'b0;
      r_fft_valid  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_enter_load) begin
            r_state      <= LOAD;
            r_load_frame <= 1'b1;
            r_busy       <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        LOAD: begin
          r_state      <= COMPUTE;
          r_load_frame <= 1'b0;
          r_bfly_en    <= 1'b1;
          r_stage      <= '0;
          r_grp        <= '0;
        end
        COMPUTE: begin
          if (r_grp == LAST_GRP) begin
            r_grp <= '0;
            if (r_stage == LAST_STAGE) begin
              r_state     <= OUTPUT;
              r_stage     <= '0;
              r_bfly_en   <= 1'b0;
              r_fft_valid <= 1'b1;
            end else begin
              r_stage <= r_stage + STAGE_W'(1);
            end
          end else begin
            r_grp <= r_grp + GRP_W'(1);
          end
        end
        OUTPUT: begin
          if (i_out_ready) begin
            r_fft_valid <= 1'b0;
            if (w_enter_load) begin
              r_state      <= LOAD;
              r_load_frame <= 1'b1;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_state <= OUTPUT;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_stage      <= '0;
          r_grp        <= '0;
          r_load_frame <= 1'b0;
          r_bfly_en    <= 1'b0;
          r_fft_valid  <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  // One-deep lookahead: a newer frame replaces a queued one and is a drop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_drop;
      if (w_enter_load) begin
        r_pend <= 1'b0;
      end else if (i_x_valid) begin
        r_pend <= 1'b1;
      end else begin
        r_pend <= r_pend;
      end
    end
  end

  sat_cnt8 #(.SATURATE(1'b0)) u_frame_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (w_accept),
    .o_cnt (o_frame_cnt)
  );

  sat_cnt8 #(.SATURATE(1'b1)) u_drop_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (w_drop),
    .o_cnt (o_drop_cnt)
  );

  assign o_load_frame = r_load_frame;
  assign o_bfly_en    = r_bfly_en;
  assign o_stage      = r_stage;
  assign o_grp        = r_grp;
  assign o_fft_valid  = r_fft_valid;
  assign o_busy       = r_busy;
  assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_fft_frame_sched.sv
// Self-checking bench for fft_frame_sched: event scoreboard plus scenario tasks.
module tb_fft_frame_sched;

  localparam int G = 2;  // groups per stage for BFLY_UNITS=4

  logic clk = 1'b0;
  logic rst, x_valid, out_ready;

  logic       load_frame, bfly_en, fft_valid, busy, overrun;
  logic [1:0] stage;
  logic [2:0] grp;
  logic [7:0] frame_cnt, drop_cnt;

  logic       load_8, bfly_8, fv_8, busy_8, ovr_8;
  logic [1:0] stage_8;
  logic [2:0] grp_8;
  logic [7:0] fcnt_8, dcnt_8;

  logic       load_1, bfly_1, fv_1, busy_1, ovr_1;
  logic [1:0] stage_1;
  logic [2:0] grp_1;
  logic [7:0] fcnt_1, dcnt_1;

  int n_tests = 0;
  int n_fail  = 0;
  int ovr_seen = 0;

  typedef struct {int kind; int stage; int grp;} ev_t;  // 1 load, 2 bfly, 3 accept
  ev_t exp_q[$];
  ev_t mon_e;
  int  mon_kind;

  always #5 clk = ~clk;

  fft_frame_sched #(.BFLY_UNITS(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_x_valid(x_valid), .i_out_ready(out_ready),
    .o_load_frame(load_frame), .o_bfly_en(bfly_en), .o_stage(stage), .o_grp(grp),
    .o_fft_valid(fft_valid), .o_busy(busy), .o_overrun(overrun),
    .o_frame_cnt(frame_cnt), .o_drop_cnt(drop_cnt));

  fft_frame_sched #(.BFLY_UNITS(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_x_valid(x_valid), .i_out_ready(out_ready),
    .o_load_frame(load_8), .o_bfly_en(bfly_8), .o_stage(stage_8), .o_grp(grp_8),
    .o_fft_valid(fv_8), .o_busy(busy_8), .o_overrun(ovr_8),
    .o_frame_cnt(fcnt_8), .o_drop_cnt(dcnt_8));

  fft_frame_sched #(.BFLY_UNITS(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_x_valid(x_valid), .i_out_ready(out_ready),
    .o_load_frame(load_1), .o_bfly_en(bfly_1), .o_stage(stage_1), .o_grp(grp_1),
    .o_fft_valid(fv_1), .o_busy(busy_1), .o_overrun(ovr_1),
    .o_frame_cnt(fcnt_1), .o_drop_cnt(dcnt_1));

  // Scoreboard monitor: pops the expected event stream of the main instance.
  always @(negedge clk) begin
    if (!rst) begin
      if (overrun) ovr_seen++;
      n_tests++;
      if ($countones({load_frame, bfly_en, fft_valid}) > 1) begin
        n_fail++;
        $display("FAIL exclusive: load/bfly/valid = %b, required at most one set",
                 {load_frame, bfly_en, fft_valid});
      end
      mon_kind = load_frame ? 1 : bfly_en ? 2 : (fft_valid && out_ready) ? 3 : 0;
      if (mon_kind != 0) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: event kind %0d stage %0d grp %0d, required none",
                   mon_kind, stage, grp);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.kind !== mon_kind || mon_e.stage !== int'(stage) || mon_e.grp !== int'(grp)) begin
            n_fail++;
            $display("FAIL sb_event: got kind %0d stage %0d grp %0d, required kind %0d stage %0d grp %0d",
                     mon_kind, stage, grp, mon_e.kind, mon_e.stage, mon_e.grp);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame();
    exp_q.push_back('{1, 0, 0});
    for (int s = 0; s < 4; s++)
      for (int g = 0; g < G; g++)
        exp_q.push_back('{2, s, g});
    exp_q.push_back('{3, 0, 0});
  endtask

  task automatic pulse_x();
    x_valid = 1'b1;
    tick();
    x_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin tick(); n++; end
    if (busy) begin
      n_tests++; n_fail++;
      $display("FAIL wait_idle: busy %0b after %0d cycles, required 0", busy, budget);
    end
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!fft_valid && n < budget) begin tick(); n++; end
    if (!fft_valid) begin
      n_tests++; n_fail++;
      $display("FAIL wait_valid: fft_valid %0b after %0d cycles, required 1", fft_valid, budget);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({load_frame, bfly_en, stage, grp, fft_valid, busy, overrun, frame_cnt, drop_cnt} !== 28'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required 0",
               {load_frame, bfly_en, stage, grp, fft_valid, busy, overrun, frame_cnt, drop_cnt});
    end
  endtask

  task automatic test_single_frame();
    out_ready = 1'b1;
    push_frame();
    pulse_x();
    n_tests++;
    if (load_frame !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_load: load %b busy %b, required 1 1", load_frame, busy);
    end
    for (int i = 0; i < 4 * G; i++) begin
      tick();
      n_tests++;
      if (bfly_en !== 1'b1 || int'(stage) !== i / G || int'(grp) !== i % G) begin
        n_fail++;
        $display("FAIL single_bfly[%0d]: en %b stage %0d grp %0d, required 1 %0d %0d",
                 i, bfly_en, stage, grp, i / G, i % G);
      end
    end
    tick();
    n_tests++;
    if (fft_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL single_valid: got %b, required 1", fft_valid);
    end
    tick();
    n_tests++;
    if (fft_valid !== 1'b0 || busy !== 1'b0 || frame_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL single_done: valid %b busy %b frame_cnt %0d, required 0 0 1",
               fft_valid, busy, frame_cnt);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    push_frame();
    pulse_x();
    wait_valid(40);
    for (int i = 0; i < 20; i++) begin
      tick();
      n_tests++;
      if (fft_valid !== 1'b1 || frame_cnt !== 8'd1) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: valid %b frame_cnt %0d, required 1 1", i, fft_valid, frame_cnt);
      end
    end
    out_ready = 1'b1;
    tick();
    n_tests++;
    if (fft_valid !== 1'b0 || frame_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL bp_accept: valid %b frame_cnt %0d, required 0 2", fft_valid, frame_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int ovr0;
    ovr0 = ovr_seen;
    out_ready = 1'b1;
    push_frame();
    pulse_x();
    repeat (3) tick();
    push_frame();
    pulse_x();
    wait_valid(40);
    tick();
    n_tests++;
    if (load_frame !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_load: load %b busy %b, required 1 1", load_frame, busy);
    end
    wait_idle(40);
    n_tests++;
    if (frame_cnt !== 8'd4 || ovr_seen !== ovr0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_done: frame_cnt %0d overruns %0d pending_exp %0d, required 4 %0d 0",
               frame_cnt, ovr_seen, exp_q.size(), ovr0);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    out_ready = 1'b0;
    push_frame();
    pulse_x();
    repeat (2) tick();
    pulse_x();
    n_tests++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_first_queue: overrun %b, required 0", overrun);
    end
    repeat (2) tick();
    pulse_x();
    n_tests++;
    if (overrun !== 1'b1 || drop_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL ovr_pulse: overrun %b drop_cnt %0d, required 1 1", overrun, drop_cnt);
    end
    tick();
    n_tests++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_one_cycle: overrun %b, required 0", overrun);
    end
    push_frame();
    out_ready = 1'b1;
    wait_idle(60);
    n_tests++;
    if (frame_cnt !== 8'd2 || drop_cnt !== 8'd1 || ovr_seen !== 1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL ovr_release: frame_cnt %0d drop_cnt %0d overruns %0d pending_exp %0d, required 2 1 1 0",
               frame_cnt, drop_cnt, ovr_seen, exp_q.size());
    end
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b0;
    push_frame();
    pulse_x();
    for (int i = 0; i < 256; i++) pulse_x();   // 1 queues, 255 drop
    n_tests++;
    if (drop_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL drop_255: drop_cnt %0d, required 255", drop_cnt);
    end
    for (int i = 0; i < 45; i++) pulse_x();
    n_tests++;
    if (drop_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL drop_sat: drop_cnt %0d, required 255", drop_cnt);
    end
    push_frame();
    out_ready = 1'b1;
    wait_idle(60);
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 255; i++) begin
      push_frame();
      pulse_x();
      wait_idle(30);
    end
    n_tests++;
    if (frame_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL frame_255: frame_cnt %0d, required 255", frame_cnt);
    end
    push_frame();
    pulse_x();
    wait_idle(30);
    n_tests++;
    if (frame_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL frame_wrap: frame_cnt %0d, required 0", frame_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    out_ready = 1'b1;
    push_frame();
    pulse_x();
    while (!(bfly_en && stage == 2'd2) && n < 30) begin tick(); n++; end
    n_tests++;
    if (!(bfly_en && stage == 2'd2)) begin
      n_fail++;
      $display("FAIL rmid_reach: bfly %b stage %0d, required 1 2", bfly_en, stage);
    end
    do_reset();
    n_tests++;
    if ({load_frame, bfly_en, stage, grp, fft_valid, busy, overrun, frame_cnt, drop_cnt} !== 28'd0) begin
      n_fail++;
      $display("FAIL rmid_outputs: got %h, required 0",
               {load_frame, bfly_en, stage, grp, fft_valid, busy, overrun, frame_cnt, drop_cnt});
    end
    for (int i = 0; i < 15; i++) begin
      tick();
      n_tests++;
      if (fft_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rmid_aborted[%0d]: valid %b busy %b, required 0 0", i, fft_valid, busy);
      end
    end
    push_frame();
    pulse_x();
    wait_idle(30);
    n_tests++;
    if (frame_cnt !== 8'd1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rmid_fresh: frame_cnt %0d pending_exp %0d, required 1 0", frame_cnt, exp_q.size());
    end
  endtask

  task automatic test_param_sweep();
    int c8 = 0;
    int c1 = 0;
    int bad8 = 0;
    int max1 = 0;
    do_reset();
    out_ready = 1'b1;
    push_frame();
    pulse_x();
    for (int i = 0; i < 60; i++) begin
      if (bfly_8) begin c8++; if (grp_8 != 3'd0) bad8++; end
      if (bfly_1) begin c1++; if (int'(grp_1) > max1) max1 = int'(grp_1); end
      tick();
    end
    n_tests++;
    if (c8 !== 4 || bad8 !== 0) begin
      n_fail++;
      $display("FAIL sweep_8: bfly cycles %0d nonzero grp %0d, required 4 0", c8, bad8);
    end
    n_tests++;
    if (c1 !== 32 || max1 !== 7) begin
      n_fail++;
      $display("FAIL sweep_1: bfly cycles %0d max grp %0d, required 32 7", c1, max1);
    end
    n_tests++;
    if (fcnt_8 !== 8'd1 || fcnt_1 !== 8'd1 || busy_8 !== 1'b0 || busy_1 !== 1'b0) begin
      n_fail++;
      $display("FAIL sweep_done: fcnt8 %0d fcnt1 %0d busy8 %b busy1 %b, required 1 1 0 0",
               fcnt_8, fcnt_1, busy_8, busy_1);
    end
  endtask

  initial begin
    rst = 1'b1;
    x_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();
    test_reset();
    repeat (2) tick();
    test_single_frame();
    test_backpressure();
    test_back_to_back();
    test_overrun();
    test_saturation();
    test_reset_mid();
    test_param_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
